jacobi_convergence_checker: RTL

JACOBI_CONVERGENCE_CHECKER -- requirements
Module: jacobi_convergence_checker

---
 rtl/jacobi_convergence_checker.sv | 101 ++++++++++
 1 files changed

// File: rtl/jacobi_convergence_checker.sv
// jacobi_convergence_checker: checks one Jacobi sweep of update differences against a tolerance
//
// Ports:
//   clk          - sole clock, all state on rising edge
//   rst_n        - asynchronous active-low reset
//   start        - one-cycle pulse, begins (or restarts) a sweep check
//   vec_len      - elements per sweep, sampled with start
//   tolerance    - IEEE-754 single threshold, sampled with start
//   diff_in      - IEEE-754 single difference x_new - x_old
//   diff_valid   - qualifies diff_in
//   busy         - high while collecting a sweep
//   done         - high once the sweep is complete, until the next start
//   converged    - sweep result, meaningful while done is high
//   nan_seen     - a NaN sample was observed in this sweep
//   max_abs_diff - running maximum of |diff_in| for this sweep
//   elem_count   - samples accepted in this sweep
module jacobi_convergence_checker #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] vec_len,
    input  logic [31:0]      tolerance,
    input  logic [31:0]      diff_in,
    input  logic             diff_valid,
    output logic             busy,
    output logic             done,
    output logic             converged,
    output logic             nan_seen,
    output logic [31:0]      max_abs_diff,
    output logic [LEN_W-1:0] elem_count
);
    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;
    state_t state, state_next;
    logic [LEN_W-1:0] len_q;
    logic [30:0]      tol_q;
    logic [LEN_W-1:0] cnt_inc;
    logic [30:0]      abs_in;
    logic [30:0]      max_next;
    logic             diff_nan;
    logic             tol_nan;
    logic             start_tol_nan;
    logic             accept;
    logic             last;
    logic             nan_next;
    logic             conv_calc;
    logic             unused_sign;

    // Magnitudes only: sign bits are dropped so -0 == +0 and ordering is a plain unsigned compare.
    assign unused_sign   = diff_in[31] ^ tolerance[31];
    assign abs_in        = diff_in[30:0];
    assign diff_nan      = &diff_in[30:23] && |diff_in[22:0];
    assign tol_nan       = &tol_q[30:23] && |tol_q[22:0];
    assign start_tol_nan = &tolerance[30:23] && |tolerance[22:0];
    // A start in COLLECT wins over a coincident sample, which is discarded.
    assign accept        = (state == COLLECT) && diff_valid && !start;
    assign cnt_inc       = elem_count + LEN_W'(1);
    assign last          = accept && (cnt_inc == len_q);
    assign max_next      = (!diff_nan && abs_in > max_abs_diff[30:0]) ? abs_in : max_abs_diff[30:0];
    assign nan_next      = nan_seen | diff_nan;
    // Verdict uses values that already include the final sample.
    assign conv_calc     = !nan_next && !tol_nan && (max_next <= tol_q);
    assign busy          = (state == COLLECT);
    assign done          = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (start)     state_next = (vec_len == '0) ? DONE : COLLECT;
        else if (last) state_next = DONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q        <= '0;
            tol_q        <= '0;
            elem_count   <= '0;
            max_abs_diff <= '0;
            nan_seen     <= 1'b0;
            converged    <= 1'b0;
        end else if (start) begin
            len_q        <= vec_len;
            tol_q        <= tolerance[30:0];
            elem_count   <= '0;
            max_abs_diff <= '0;
            nan_seen     <= 1'b0;
            // An empty sweep is trivially converged unless the threshold itself is NaN.
            converged    <= (vec_len == '0) && !start_tol_nan;
        end else if (accept) begin
            elem_count   <= cnt_inc;
            max_abs_diff <= {1'b0, max_next};
            nan_seen     <= nan_next;
            if (last) converged <= conv_calc;
        end
    end
endmodule
